// File: rtl/wb_pkg.sv
// Shared encodings for the registered writeback stage: source selects, load funct3, fault causes, FSM states.
package wb_pkg;

    localparam logic [1:0] WB_PC     = 2'd0;
    localparam logic [1:0] WB_RESULT = 2'd1;
    localparam logic [1:0] WB_LOAD   = 2'd2;
    localparam logic [1:0] WB_CSR    = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Load formatter: picks byte/half/word from an aligned word and extends it; flags bad funct3 and misalignment.
// Purely combinational, no handshake.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o,
    output logic            illegal_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata_i[8*addr_lo_i +: 8];
    assign half_v = rdata_i[16*addr_lo_i[1] +: 16];

    always_comb begin
        data_o       = rdata_i;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH: begin
                data_o       = {{(XLEN-16){half_v[15]}}, half_v};
                misaligned_o = addr_lo_i[0];
            end
            F3_LHU: begin
                data_o       = {{(XLEN-16){1'b0}}, half_v};
                misaligned_o = addr_lo_i[0];
            end
            F3_LW:   misaligned_o = (addr_lo_i != 2'b00);
            default: illegal_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered RV32I writeback: 1-cycle latency for ALU/PC/CSR and zero-wait loads; loads without a response
// park in WAIT (in_ready low, load_pending high) until rvalid or LOAD_TIMEOUT cycles elapse.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_pc_next,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_csr_data,
    input  logic [4:0]      in_rd_addr,
    input  logic            in_rd_we,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            load_pending,
    output logic            load_exc,
    output logic [1:0]      load_exc_cause
);

    localparam int            CW       = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

    wb_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic            ld_we_q, ld_we_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_lo_q, ld_lo_d;
    logic            rd_we_q, rd_we_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            exc_q, exc_d;
    logic [1:0]      cause_q, cause_d;

    logic            accept, is_load, load_ok, timeout;
    logic [2:0]      al_f3;
    logic [1:0]      al_lo;
    logic [XLEN-1:0] al_data;
    logic            al_mis, al_ill;

    assign in_ready     = (state_q == ST_IDLE) & ~rst;
    assign load_pending = (state_q == ST_WAIT);
    assign accept       = in_valid & in_ready;
    assign is_load      = (in_wb_sel == WB_LOAD);
    assign load_ok      = accept & is_load & ~al_ill & ~al_mis;
    assign timeout      = (cnt_q == CNT_LAST);

    // In WAIT the formatter must see the parked load, not whatever MEM is presenting now.
    assign al_f3 = (state_q == ST_WAIT) ? ld_f3_q : in_funct3;
    assign al_lo = (state_q == ST_WAIT) ? ld_lo_q : in_addr_lo;

    load_align #(.XLEN(XLEN)) u_align (
        .rdata_i      (dmem_rdata),
        .funct3_i     (al_f3),
        .addr_lo_i    (al_lo),
        .data_o       (al_data),
        .misaligned_o (al_mis),
        .illegal_o    (al_ill)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= '0;
            ld_we_q   <= 1'b0;
            ld_f3_q   <= '0;
            ld_lo_q   <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            exc_q     <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_rd_q   <= ld_rd_d;
            ld_we_q   <= ld_we_d;
            ld_f3_q   <= ld_f3_d;
            ld_lo_q   <= ld_lo_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            exc_q     <= exc_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load_ok && !dmem_rvalid) state_d = ST_WAIT;
            ST_WAIT: if (dmem_rvalid || timeout)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        ld_rd_d   = ld_rd_q;
        ld_we_d   = ld_we_q;
        ld_f3_d   = ld_f3_q;
        ld_lo_d   = ld_lo_q;
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        exc_d     = 1'b0;
        cause_d   = CAUSE_NONE;
        if (state_q == ST_IDLE) begin
            if (accept && !is_load) begin
                if (in_rd_we && in_rd_addr != 5'd0) begin
                    rd_we_d   = 1'b1;
                    rd_addr_d = in_rd_addr;
                    case (in_wb_sel)
                        WB_PC:   rd_data_d = in_pc_next;
                        WB_CSR:  rd_data_d = in_csr_data;
                        default: rd_data_d = in_result;
                    endcase
                end
            end else if (accept && al_ill) begin
                exc_d   = 1'b1;
                cause_d = CAUSE_ILLEGAL;
            end else if (accept && al_mis) begin
                exc_d   = 1'b1;
                cause_d = CAUSE_MISALIGN;
            end else if (load_ok) begin
                ld_rd_d = in_rd_addr;
                ld_we_d = in_rd_we;
                ld_f3_d = in_funct3;
                ld_lo_d = in_addr_lo;
                cnt_d   = '0;
                if (dmem_rvalid && in_rd_we && in_rd_addr != 5'd0) begin
                    rd_we_d   = 1'b1;
                    rd_addr_d = in_rd_addr;
                    rd_data_d = al_data;
                end
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
            if (dmem_rvalid) begin
                if (ld_we_q && ld_rd_q != 5'd0) begin
                    rd_we_d   = 1'b1;
                    rd_addr_d = ld_rd_q;
                    rd_data_d = al_data;
                end
            end else if (timeout) begin
                exc_d   = 1'b1;
                cause_d = CAUSE_TIMEOUT;
            end
        end
    end

    assign rd_we          = rd_we_q;
    assign rd_addr        = rd_addr_q;
    assign rd_data        = rd_data_q;
    assign load_exc       = exc_q;
    assign load_exc_cause = cause_q;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Registered RV32I writeback stage; successor to the combinational writeback select.
- Selects rd write data from four sources: pc_next, ALU result, load data, CSR read data.
- Formats load data by byte offset and funct3 (sign/zero extension).
- Waits for variable-latency data-memory responses using a valid/ready handshake, with timeout and exception reporting.
- Sits between the MEM stage and the register file; its stall output feeds the hazard unit.

Parameters:
- XLEN, 32, datapath width; the RV32I core uses 32 only.
- LOAD_TIMEOUT, 16, maximum cycles spent in WAIT before a load fault is raised; must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_wb_sel  in  2  source select: 0 pc_next, 1 result, 2 load, 3 csr.
- in_pc_next  in  XLEN  PC+4.
- in_result  in  XLEN  ALU result.
- in_csr_data  in  XLEN  CSR read value.
- in_rd_addr  in  5  destination register.
- in_rd_we  in  1  instruction writes rd.
- in_funct3  in  3  load type.
- in_addr_lo  in  2  byte offset of the load address.
- dmem_rvalid  in  1  load response valid.
- dmem_rdata  in  XLEN  load response word (aligned word).
- rd_we  out  1  register-file write enable; one-cycle pulse.
- rd_addr  out  5  register-file write address.
- rd_data  out  XLEN  register-file write data.
- load_pending  out  1  stall request; high while in WAIT.
- load_exc  out  1  load exception; one-cycle pulse.
- load_exc_cause  out  2  1 misaligned, 2 illegal funct3, 3 timeout; 0 otherwise.

Behaviour:
- Reset:
  - clk is the only clock.
  - rst is synchronous, active-high.
  - On reset: state=IDLE; rd_we=0, rd_addr=0, rd_data=0, load_exc=0, load_exc_cause=0, timeout counter=0.
  - Reset during WAIT drops the pending load with no write and no exception.
- Accept = in_valid & in_ready.
  - in_ready = (state==IDLE) & ~rst.
  - load_pending = (state==WAIT).
- IDLE, sel ∈ {0,1,3}:
  - Next cycle: rd_we = in_rd_we & (in_rd_addr!=0); rd_addr = in_rd_addr; rd_data = selected source.
  - Latency 1; throughput one instruction per cycle.
- IDLE, sel=2, load checks:
  - Illegal funct3 (011, 110, 111) → next cycle load_exc=1, cause=2, rd_we=0.
  - Otherwise misaligned (LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0) → next cycle load_exc=1, cause=1, rd_we=0.
  - Illegal funct3 takes priority over misalignment.
- IDLE, sel=2, valid load:
  - Latch rd_addr, rd_we, funct3, addr_lo.
  - If dmem_rvalid is high in the same cycle: write formatted data next cycle, stay IDLE.
  - Otherwise go to WAIT with the counter cleared.
- WAIT:
  - The counter increments each cycle.
  - On dmem_rvalid: next cycle write the formatted data (x0 suppressed), go to IDLE.
  - When the counter reaches LOAD_TIMEOUT without rvalid: next cycle load_exc=1, cause=3, rd_we=0, go to IDLE.
  - rvalid in the same cycle the counter reaches LOAD_TIMEOUT counts as success.
- Load formatting:
  - LB/LBU select byte dmem_rdata[8*addr_lo +: 8]; LH/LHU select half [16*addr_lo[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Ignored and idle conditions:
  - dmem_rvalid in IDLE with no accepted load is ignored.
  - When nothing is written, rd_data and rd_addr hold their previous values.
  - rd_we, load_exc and the cause output are 0 in all cycles not listed above.

Decomposition:
- Shared package wb_pkg:
  - WB_PC=0, WB_RESULT=1, WB_LOAD=2, WB_CSR=3.
  - Load funct3 codes: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Cause codes: CAUSE_MISALIGN=1, CAUSE_ILLEGAL=2, CAUSE_TIMEOUT=3.
  - State encoding IDLE/WAIT.
- Sub-module load_align: combinational formatter taking rdata, funct3 and addr_lo; outputs formatted data, misaligned and illegal flags.

Test Plan:
- Back-to-back ALU traffic: sel=1 with result=0x0000_1234, rd=5, then sel=0 with pc_next=0x0000_0104, rd=1 in consecutive cycles → rd_we pulses on two consecutive cycles, data 0x1234 then 0x104; in_ready stays 1.
- Signed byte load: LB, addr_lo=3, accepted with no rvalid; rvalid arrives 3 cycles later with rdata=0x80FF_0000 → load_pending high for 3 cycles; next cycle rd_data=0xFFFF_FF80, rd_we=1.
- Unsigned half load, zero wait: LHU, addr_lo=2, with rvalid in the accept cycle and rdata=0xBEEF_0001 → next cycle rd_data=0x0000_BEEF; no stall.
- Load exceptions: LW with addr_lo=1 → load_exc=1, cause=1, rd_we=0; funct3=111 with addr_lo=1 → cause=2.
- Timeout: LOAD_TIMEOUT=4 with no rvalid → load_exc=1, cause=3 on the cycle after 4 WAIT cycles; a late rvalid afterwards is ignored.
- Reset and x0: rst asserted during WAIT → the following cycle is IDLE, with no write and no exception; result load to rd=0 → rd_we stays 0.
